// File: rtl/shift_right_seq.sv
// Sequential right shifter (logical/arithmetic), one step per SHIFT cycle.
// Optional macro SHIFT_RIGHT_SEQ_FAST_EN: step by 4 while at least 4 positions remain.
module shift_right_seq #(
  parameter int NB_DATA  = 32,
  parameter int NB_SHAMT = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [NB_SHAMT-1:0] i_shamt,
  input  logic                i_arith,
  output logic                o_ready,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [NB_DATA-1:0]  o_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                     state;
  logic signed [NB_DATA-1:0]  work;
  logic [NB_SHAMT-1:0]        cnt;
  logic                       arith_r;
  logic [NB_SHAMT-1:0]        step;
  logic                       fill;

  // Shift right by amt, filling vacated positions with f.
  function automatic logic signed [NB_DATA-1:0] shr_fill(
    input logic signed [NB_DATA-1:0] d,
    input logic                      f,
    input logic [NB_SHAMT-1:0]       amt
  );
    logic signed [NB_DATA:0] ext;
    ext = $signed({f, d}) >>> amt;
    return ext[NB_DATA-1:0];
  endfunction

  // In arithmetic mode the working MSB never changes, so it is the operand sign.
  assign fill = arith_r & work[NB_DATA-1];

`ifdef SHIFT_RIGHT_SEQ_FAST_EN
  assign step = (cnt >= NB_SHAMT'(4)) ? NB_SHAMT'(4) : NB_SHAMT'(1);
`else
  assign step = NB_SHAMT'(1);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      work    <= '0;
      cnt     <= '0;
      arith_r <= 1'b0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            work    <= i_data;
            cnt     <= i_shamt;
            arith_r <= i_arith;
            o_ready <= 1'b0;
            if (i_shamt != '0) begin
              state <= SHIFT;
            end else begin
              state   <= DONE;
              o_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= shr_fill(work, fill, step);
          cnt  <= cnt - step;
          if (cnt == step) begin
            state   <= DONE;
            o_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_data = work;

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: directed corner cases plus random operations vs a reference model.
module tb_shift_right_seq;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_data;
  logic [4:0]  i_shamt;
  logic        i_arith;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  shift_right_seq #(.NB_DATA(32), .NB_SHAMT(5)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_shamt (i_shamt),
    .i_arith (i_arith),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input bit ar);
    if (ar) return 32'($signed(d) >>> sh);
    return d >> sh;
  endfunction

  // Clock edges after the accept edge until o_valid is seen; a zero shift is ready right away.
  function automatic int ref_edges(input int sh);
`ifdef SHIFT_RIGHT_SEQ_FAST_EN
    return sh / 4 + sh % 4;
`else
    return sh;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] d, input int sh, input bit ar, input int hold);
    logic [31:0] exp;
    int n;
    exp = ref_shift(d, sh, ar);
    @(negedge i_clk);
    chk("ready_idle", {31'b0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_data  = d;
    i_shamt = 5'(sh);
    i_arith = ar;
    i_ready = 1'b0;
    @(posedge i_clk);
    #1;
    // Requests presented while busy must be ignored.
    i_data  = $urandom;
    i_shamt = 5'($urandom);
    i_arith = 1'($urandom);
    n = 0;
    while (o_valid !== 1'b1 && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(ref_edges(sh)));
    chk("result", o_data, exp);
    for (int k = 0; k < hold; k++) begin
      i_data = $urandom;
      @(posedge i_clk);
      #1;
      chk("hold_valid", {31'b0, o_valid}, 32'd1);
      chk("hold_data", o_data, exp);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    chk("release_valid", {31'b0, o_valid}, 32'd0);
    chk("release_ready", {31'b0, o_ready}, 32'd1);
    i_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          sh;
    bit          ar;
    int          seen_valid;

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_shamt = '0;
    i_arith = 1'b0;
    i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_data", o_data, 32'd0);

    // Reset wins over a simultaneous accept.
    i_valid = 1'b1;
    i_data  = 32'hDEADBEEF;
    i_shamt = 5'd3;
    @(posedge i_clk);
    #1;
    chk("rst_prio_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_prio_data", o_data, 32'd0);
    i_valid = 1'b0;
    i_reset = 1'b0;

    run_op(32'h80000000, 4, 1'b1, 0);
    run_op(32'h80000000, 4, 1'b0, 0);
    run_op(32'h00000FFF, 0, 1'b0, 0);
    run_op(32'hFFFF8000, 31, 1'b1, 0);
    run_op(32'hFFFF8000, 31, 1'b0, 0);
    run_op(32'h00007000, 12, 1'b0, 5);
    run_op(32'h7FFFFFFF, 31, 1'b1, 1);
    run_op(32'h12345678, 1, 1'b1, 0);

    // Abort a long shift with reset three cycles after accept.
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = 32'hFFFFFFFF;
    i_shamt = 5'd20;
    i_arith = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    seen_valid = 0;
    repeat (2) begin
      @(posedge i_clk);
      #1;
      if (o_valid === 1'b1) seen_valid++;
    end
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("abort_valid", {31'b0, o_valid}, 32'd0);
    chk("abort_ready", {31'b0, o_ready}, 32'd1);
    chk("abort_data", o_data, 32'd0);
    repeat (25) begin
      @(posedge i_clk);
      #1;
      if (o_valid === 1'b1) seen_valid++;
    end
    chk("abort_no_result", 32'(seen_valid), 32'd0);
    run_op(32'h00000FFF, 4, 1'b0, 1);

    for (int t = 0; t < 40; t++) begin
      d  = $urandom;
      sh = $urandom_range(0, 31);
      ar = 1'($urandom);
      run_op(d, sh, ar, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
